tcon_cfg_sched: RTL and testbench

- Frame-synchronous configuration scheduler for the LCD timing controller's display-mode inputs: threshold (8-bit) and test-mode enable.
- Two requesters share one configuration path: requester 0 is the switch/key front-end, requester 1 is the touch/host side. Arbitration is round-robin.
- A granted update is applied only at start-of-frame (falling edge of LCD vertical sync), so a frame never shows mixed settings.
- Outputs drive the timing controller's threshold and test-mode inputs directly.

---
 rtl/tcon_cfg_sched.sv | 136 +++++++++++++
 tb/tb_tcon_cfg_sched.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcon_cfg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tcon_cfg_sched: frame-synchronous round-robin config scheduler for the   |
// | LCD timing controller threshold / test-mode inputs.                      |
// | Optional auto-sweep: define TCON_CFG_AUTO_SWEEP_EN.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tcon_cfg_sched #(
  parameter logic [7:0] THRESH_RESET = 8'd128,
  parameter logic [7:0] SWEEP_FRAMES = 8'd8,
  parameter logic [7:0] SWEEP_STEP   = 8'd4
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iVD,
  input  logic        iREQ0,
  input  logic [7:0]  iTHRESH0,
  input  logic        iTEST0,
  output logic        oACK0,
  input  logic        iREQ1,
  input  logic [7:0]  iTHRESH1,
  input  logic        iTEST1,
  output logic        oACK1,
  output logic [7:0]  oTHRESH,
  output logic        oTEST_MODE,
  output logic        oBUSY,
  output logic [15:0] oFRAME_CNT
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic        r_vd_q;
  logic [0:0]  r_state;
  logic        r_last_grant;
  logic [7:0]  r_pend_thresh;
  logic        r_pend_test;
  logic [7:0]  r_thresh;
  logic        r_test;
  logic        r_ack0;
  logic        r_ack1;
  logic [15:0] r_frame_cnt;

  logic w_sof;
  logic w_any_req;
  logic w_grant;
  logic w_commit;

  assign w_sof     = r_vd_q & ~iVD;
  assign w_any_req = iREQ0 | iREQ1;
  // 1 selects requester 1; on contention the one not granted last time wins
  assign w_grant   = iREQ1 & (~iREQ0 | ~r_last_grant);
  assign w_commit  = (r_state == S_PEND) & w_sof;

`ifdef TCON_CFG_AUTO_SWEEP_EN
  logic [7:0] r_sweep_cnt;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_sweep_cnt <= 8'd0;
    end else if (!r_test || w_commit) begin
      r_sweep_cnt <= 8'd0;
    end else if ((r_state == S_IDLE) && !w_any_req && w_sof) begin
      if (r_sweep_cnt == SWEEP_FRAMES - 8'd1) begin
        r_sweep_cnt <= 8'd0;
      end else begin
        r_sweep_cnt <= r_sweep_cnt + 8'd1;
      end
    end
  end

  logic w_sweep_step;
  assign w_sweep_step = r_test && (r_state == S_IDLE) && !w_any_req && w_sof &&
                        (r_sweep_cnt == SWEEP_FRAMES - 8'd1);
`else
  logic [15:0] w_unused_sweep;
  assign w_unused_sweep = {SWEEP_FRAMES, SWEEP_STEP};
`endif

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_vd_q        <= 1'b1;
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_pend_thresh <= 8'd0;
      r_pend_test   <= 1'b0;
      r_thresh      <= THRESH_RESET;
      r_test        <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_frame_cnt   <= 16'd0;
    end else begin
      r_vd_q <= iVD;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_sof) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          // A sof coinciding with capture is not used; commit waits one frame
          if (w_any_req) begin
            r_last_grant  <= w_grant;
            r_pend_thresh <= w_grant ? iTHRESH1 : iTHRESH0;
            r_pend_test   <= w_grant ? iTEST1 : iTEST0;
            r_state       <= S_PEND;
          end
`ifdef TCON_CFG_AUTO_SWEEP_EN
          if (w_sweep_step) begin
            r_thresh <= r_thresh + SWEEP_STEP;
          end
`endif
        end
        S_PEND: begin
          if (w_sof) begin
            r_thresh <= r_pend_thresh;
            r_test   <= r_pend_test;
            r_ack0   <= ~r_last_grant;
            r_ack1   <= r_last_grant;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oACK0      = r_ack0;
  assign oACK1      = r_ack1;
  assign oTHRESH    = r_thresh;
  assign oTEST_MODE = r_test;
  assign oBUSY      = (r_state == S_PEND);
  assign oFRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tcon_cfg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tcon_cfg_sched: directed self-checking bench for tcon_cfg_sched.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_tcon_cfg_sched;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iVD = 1'b1;
  logic        iREQ0 = 1'b0;
  logic [7:0]  iTHRESH0 = 8'd0;
  logic        iTEST0 = 1'b0;
  logic        oACK0;
  logic        iREQ1 = 1'b0;
  logic [7:0]  iTHRESH1 = 8'd0;
  logic        iTEST1 = 1'b0;
  logic        oACK1;
  logic [7:0]  oTHRESH;
  logic        oTEST_MODE;
  logic        oBUSY;
  logic [15:0] oFRAME_CNT;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  tcon_cfg_sched #(
    .THRESH_RESET(8'd128),
    .SWEEP_FRAMES(8'd2),
    .SWEEP_STEP  (8'd4)
  ) dut (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .iVD       (iVD),
    .iREQ0     (iREQ0),
    .iTHRESH0  (iTHRESH0),
    .iTEST0    (iTEST0),
    .oACK0     (oACK0),
    .iREQ1     (iREQ1),
    .iTHRESH1  (iTHRESH1),
    .iTEST1    (iTEST1),
    .oACK1     (oACK1),
    .oTHRESH   (oTHRESH),
    .oTEST_MODE(oTEST_MODE),
    .oBUSY     (oBUSY),
    .oFRAME_CNT(oFRAME_CNT)
  );

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST_n = 1'b0;
    iREQ0 = 1'b0;
    iREQ1 = 1'b0;
    iVD = 1'b1;
    tick();
    tick();
    iRST_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int acks;
    do_reset();
    checks++;
    if (oTHRESH !== 8'd128 || oTEST_MODE !== 1'b0 || oBUSY !== 1'b0 ||
        oACK0 !== 1'b0 || oACK1 !== 1'b0 || oFRAME_CNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got thresh=%0d test=%b busy=%b ack=%b%b cnt=%0d, want 128 0 0 00 0",
               oTHRESH, oTEST_MODE, oBUSY, oACK0, oACK1, oFRAME_CNT);
    end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) begin
        tick();
        acks += int'(oACK0) + int'(oACK1);
      end
      iVD = 1'b0;
      repeat (3) begin
        tick();
        acks += int'(oACK0) + int'(oACK1);
      end
      iVD = 1'b1;
    end
    tick();
    checks++;
    if (oFRAME_CNT !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want 3", oFRAME_CNT);
    end
    checks++;
    if (oTHRESH !== 8'd128 || oTEST_MODE !== 1'b0 || oBUSY !== 1'b0 || acks != 0) begin
      errors++;
      $display("FAIL idle_frames: got thresh=%0d test=%b busy=%b acks=%0d, want 128 0 0 0",
               oTHRESH, oTEST_MODE, oBUSY, acks);
    end
  endtask

  task automatic test_single();
    iREQ0 = 1'b1;
    iTHRESH0 = 8'd60;
    iTEST0 = 1'b1;
    tick();
    checks++;
    if (oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b want 1", oBUSY);
    end
    repeat (99) tick();
    checks++;
    if (oTHRESH !== 8'd128 || oTEST_MODE !== 1'b0 || oACK0 !== 1'b0) begin
      errors++;
      $display("FAIL single_hold: got thresh=%0d test=%b ack0=%b want 128 0 0",
               oTHRESH, oTEST_MODE, oACK0);
    end
    iVD = 1'b0;
    tick();
    checks++;
    if (oTHRESH !== 8'd60 || oTEST_MODE !== 1'b1 || oACK0 !== 1'b1 ||
        oACK1 !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_commit: got thresh=%0d test=%b ack=%b%b busy=%b want 60 1 10 0",
               oTHRESH, oTEST_MODE, oACK0, oACK1, oBUSY);
    end
    iREQ0 = 1'b0;
    tick();
    iVD = 1'b1;
    checks++;
    if (oACK0 !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_width: got ack0=%b busy=%b want 0 0", oACK0, oBUSY);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    iREQ0 = 1'b1; iTHRESH0 = 8'd11; iTEST0 = 1'b0;
    iREQ1 = 1'b1; iTHRESH1 = 8'd22; iTEST1 = 1'b1;
    tick();
    repeat (5) tick();
    iVD = 1'b0;
    tick();
    checks++;
    if (oTHRESH !== 8'd11 || oTEST_MODE !== 1'b0 || oACK0 !== 1'b1 ||
        oACK1 !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got thresh=%0d test=%b ack=%b%b busy=%b want 11 0 10 0",
               oTHRESH, oTEST_MODE, oACK0, oACK1, oBUSY);
    end
    iREQ0 = 1'b0;
    iVD = 1'b1;
    tick();
    checks++;
    if (oBUSY !== 1'b1 || oACK0 !== 1'b0 || oACK1 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_capture: got busy=%b ack=%b%b want 1 00", oBUSY, oACK0, oACK1);
    end
    iTHRESH1 = 8'd99;
    iTEST1 = 1'b0;
    repeat (5) tick();
    iVD = 1'b0;
    tick();
    checks++;
    if (oTHRESH !== 8'd22 || oTEST_MODE !== 1'b1 || oACK1 !== 1'b1 || oACK0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_commit: got thresh=%0d test=%b ack=%b%b want 22 1 01",
               oTHRESH, oTEST_MODE, oACK0, oACK1);
    end
    iREQ1 = 1'b0;
    iVD = 1'b1;
    tick();
  endtask

  task automatic test_req_at_sof();
    iREQ0 = 1'b1; iTHRESH0 = 8'd77; iTEST0 = 1'b0;
    iVD = 1'b0;
    tick();
    checks++;
    if (oBUSY !== 1'b1 || oTHRESH !== 8'd22 || oACK0 !== 1'b0) begin
      errors++;
      $display("FAIL sof_same_cycle: got busy=%b thresh=%0d ack0=%b want 1 22 0",
               oBUSY, oTHRESH, oACK0);
    end
    tick();
    iVD = 1'b1;
    repeat (4) tick();
    iVD = 1'b0;
    tick();
    checks++;
    if (oTHRESH !== 8'd77 || oTEST_MODE !== 1'b0 || oACK0 !== 1'b1) begin
      errors++;
      $display("FAIL sof_next_commit: got thresh=%0d test=%b ack0=%b want 77 0 1",
               oTHRESH, oTEST_MODE, oACK0);
    end
    iREQ0 = 1'b0;
    iVD = 1'b1;
    tick();
  endtask

  task automatic test_reset_in_pend();
    iREQ0 = 1'b1; iTHRESH0 = 8'd10; iTEST0 = 1'b1;
    tick();
    checks++;
    if (oBUSY !== 1'b1) begin
      errors++;
      $display("FAIL pend_busy: got %b want 1", oBUSY);
    end
    iRST_n = 1'b0;
    #2;
    checks++;
    if (oTHRESH !== 8'd128 || oBUSY !== 1'b0 || oTEST_MODE !== 1'b0 || oACK0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got thresh=%0d busy=%b test=%b ack0=%b want 128 0 0 0",
               oTHRESH, oBUSY, oTEST_MODE, oACK0);
    end
    iREQ0 = 1'b0;
    tick();
    iRST_n = 1'b1;
    tick();
    iVD = 1'b0;
    tick();
    checks++;
    if (oTHRESH !== 8'd128 || oTEST_MODE !== 1'b0 || oACK0 !== 1'b0 || oBUSY !== 1'b0) begin
      errors++;
      $display("FAIL dropped_pend: got thresh=%0d test=%b ack0=%b busy=%b want 128 0 0 0",
               oTHRESH, oTEST_MODE, oACK0, oBUSY);
    end
    iVD = 1'b1;
    tick();
  endtask

  task automatic sof();
    iVD = 1'b0;
    tick();
    iVD = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_sweep();
    logic [7:0] exp2;
    logic [7:0] exp4;
`ifdef TCON_CFG_AUTO_SWEEP_EN
    exp2 = 8'd0;
    exp4 = 8'd4;
`else
    exp2 = 8'd252;
    exp4 = 8'd252;
`endif
    do_reset();
    iREQ0 = 1'b1; iTHRESH0 = 8'd252; iTEST0 = 1'b1;
    tick();
    iVD = 1'b0;
    tick();
    iREQ0 = 1'b0;
    iVD = 1'b1;
    tick();
    checks++;
    if (oTHRESH !== 8'd252 || oTEST_MODE !== 1'b1) begin
      errors++;
      $display("FAIL sweep_setup: got thresh=%0d test=%b want 252 1", oTHRESH, oTEST_MODE);
    end
    sof();
    checks++;
    if (oTHRESH !== 8'd252) begin
      errors++;
      $display("FAIL sweep_1: got %0d want 252", oTHRESH);
    end
    sof();
    checks++;
    if (oTHRESH !== exp2) begin
      errors++;
      $display("FAIL sweep_2: got %0d want %0d", oTHRESH, exp2);
    end
    sof();
    sof();
    checks++;
    if (oTHRESH !== exp4) begin
      errors++;
      $display("FAIL sweep_4: got %0d want %0d", oTHRESH, exp4);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_req_at_sof();
    test_reset_in_pend();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
